// File: rtl/audio_pkg.sv
// Shared audio-path constants, sample types and the offset-binary to
// two's-complement conversion used by the I2S serializer.
package audio_pkg;
   localparam int SAMPLE_W     = 18;
   localparam int FRAME_BITS   = 64;
   localparam int SLOT_BITS    = 32;
   localparam int TICK_SLOT    = 48;
   localparam int CAPTURE_SLOT = 63;

   typedef logic [SAMPLE_W-1:0] sample_t;

   localparam sample_t MIDSCALE = 18'h20000;

   typedef struct packed {
      sample_t l;
      sample_t r;
   } stereo_t;

   // Offset binary and two's complement differ only in the MSB.
   function automatic sample_t offset_to_twos(input sample_t s);
      return s ^ MIDSCALE;
   endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// BCLK divider and 64-slot frame counter; every output is a flop or a
// decode of one flop, so bclk/lrclk are glitch-free.
module i2s_clkgen #(
   parameter int BCLK_HALF = 8
) (
   input  logic       clk,
   input  logic       rst,
   output logic       bclk,
   output logic       lrclk,
   output logic       fall_en,
   output logic [5:0] slot
);
   localparam int DIV_W = $clog2(2 * BCLK_HALF);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * BCLK_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_HALF);

   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       slot_q, slot_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;

   // fall_en marks the cycle whose closing edge is the BCLK falling edge.
   always_comb begin
      fall_en = (div_q == DIV_LAST);
      div_d   = fall_en ? '0 : div_q + 1'b1;
      slot_d  = fall_en ? slot_q + 6'd1 : slot_q;
      bclk_d  = (div_d >= DIV_HALF);
      lrclk_d = slot_d[5];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         slot_q  <= '0;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         slot_q  <= slot_d;
         bclk_q  <= bclk_d;
         lrclk_q <= lrclk_d;
      end
   end

   assign bclk  = bclk_q;
   assign lrclk = lrclk_q;
   assign slot  = slot_q;
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter and audio timing master: frame tick, stereo capture,
// offset-to-two's-complement conversion and MSB-first serialization.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int BCLK_HALF = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sound_l,
   input  logic [SAMPLE_W-1:0] sound_r,
   input  logic                mute,
   output logic                tick48k,
   output logic                i2s_bclk,
   output logic                i2s_lrclk,
   output logic                i2s_sdata
);
   logic       fall_en;
   logic [5:0] slot, slot_nxt;

   i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
      .clk    (clk),
      .rst    (rst),
      .bclk   (i2s_bclk),
      .lrclk  (i2s_lrclk),
      .fall_en(fall_en),
      .slot   (slot)
   );

   stereo_t hold_q, hold_d;
   sample_t sr_q, sr_d;
   logic    sdata_q, sdata_d;
   logic    tick_q, tick_d;
   logic    slot_start_q, slot_start_d;

   always_comb begin
      slot_nxt     = slot + 6'd1;
      slot_start_d = fall_en;
      tick_d       = fall_en && (slot_nxt == 6'(TICK_SLOT));

      hold_d = hold_q;
      if (slot_start_q && (slot == 6'(CAPTURE_SLOT))) begin
         if (mute) begin
            hold_d = '0;
         end else begin
            hold_d.l = offset_to_twos(sound_l);
            hold_d.r = offset_to_twos(sound_r);
         end
      end

      // One-bit I2S delay: load on the slot before the MSB, shift after.
      sr_d    = sr_q;
      sdata_d = sdata_q;
      if (fall_en) begin
         sdata_d = 1'b0;
         if (slot_nxt == 6'd0) begin
            sr_d = hold_q.l;
         end else if (slot_nxt == 6'(SLOT_BITS)) begin
            sr_d = hold_q.r;
         end else if ((slot_nxt[4:0] != 5'd0) && (slot_nxt[4:0] <= 5'(SAMPLE_W))) begin
            sdata_d = sr_q[SAMPLE_W-1];
            sr_d    = {sr_q[SAMPLE_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= '0;
         sr_q         <= '0;
         sdata_q      <= 1'b0;
         tick_q       <= 1'b0;
         slot_start_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         sr_q         <= sr_d;
         sdata_q      <= sdata_d;
         tick_q       <= tick_d;
         slot_start_q <= slot_start_d;
      end
   end

   assign tick48k   = tick_q;
   assign i2s_sdata = sdata_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at BCLK_HALF=2: frame timing, serialized data,
// full-scale conversion, mute, input stability and mid-frame reset.
module tb_i2s_tx;
   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] sound_l, sound_r;
   logic        mute;
   logic        tick48k, i2s_bclk, i2s_lrclk, i2s_sdata;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

   i2s_tx #(.BCLK_HALF(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sound_l  (sound_l),
      .sound_r  (sound_r),
      .mute     (mute),
      .tick48k  (tick48k),
      .i2s_bclk (i2s_bclk),
      .i2s_lrclk(i2s_lrclk),
      .i2s_sdata(i2s_sdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Expected wire pattern indexed by slot, from hand-converted two's-complement words.
   function automatic logic [63:0] frame_of(input logic [17:0] l, input logic [17:0] r);
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 18; i++) begin
         f[1 + i]  = l[17 - i];
         f[33 + i] = r[17 - i];
      end
      return f;
   endfunction

   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end while (!tick48k && n < limit);
   endtask

   task automatic run_setup(input logic [17:0] l, input logic [17:0] r, input logic m);
      int n;
      wait_tick(400, n);
      chk("tick_seen", 64'(tick48k), 64'd1);
      sound_l = l;
      sound_r = r;
      mute    = m;
   endtask

   // Samples each slot mid-way through BCLK high; optionally changes inputs mid-frame.
   task automatic sample_frame(input int first, input int chg, input logic [17:0] cl,
                               input logic cm, output logic [63:0] sd, output logic [63:0] lr);
      for (int s = 0; s < 64; s++) begin
         repeat ((s == 0) ? first : 4) @(posedge clk);
         @(negedge clk);
         sd[s] = i2s_sdata;
         lr[s] = i2s_lrclk;
         if (s == chg) begin
            sound_l = cl;
            mute    = cm;
         end
      end
   endtask

   initial begin
      int          n;
      logic [7:0]  bh;
      logic [63:0] sd, lr;

      rst     = 1'b1;
      sound_l = 18'h20000;
      sound_r = 18'h20000;
      mute    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({tick48k, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);

      rst = 1'b0;
      n   = 0;
      bh  = '0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (n <= 8) bh[n-1] = i2s_bclk;
      end while (!tick48k && n < 400);
      chk("first_tick_clk", 64'(n), 64'd192);
      chk("bclk_wave", 64'(bh), 64'h66);

      @(posedge clk);
      @(negedge clk);
      chk("tick_width", 64'(tick48k), 64'd0);
      wait_tick(400, n);
      chk("tick_period", 64'(n + 1), 64'd256);

      sound_l = 18'h2A5A5;
      sound_r = 18'h1FFFF;
      sample_frame(66, -1, 18'h0, 1'b0, sd, lr);
      chk("serial_data", sd, frame_of(18'h0A5A5, 18'h3FFFF));
      chk("serial_lrclk", lr, LR_EXP);

      run_setup(18'h3FFFF, 18'h00000, 1'b0);
      sample_frame(66, -1, 18'h0, 1'b0, sd, lr);
      chk("full_scale_data", sd, frame_of(18'h1FFFF, 18'h20000));
      chk("full_scale_lrclk", lr, LR_EXP);

      run_setup(18'h20000, 18'h20000, 1'b0);
      sample_frame(66, -1, 18'h0, 1'b0, sd, lr);
      chk("midscale_data", sd, 64'd0);
      chk("midscale_lrclk", lr, LR_EXP);

      run_setup(18'h3FFFF, 18'h3FFFF, 1'b1);
      sample_frame(66, -1, 18'h0, 1'b0, sd, lr);
      chk("mute_data", sd, 64'd0);

      run_setup(18'h2A5A5, 18'h1FFFF, 1'b0);
      sample_frame(66, 10, 18'h2A5A5, 1'b1, sd, lr);
      chk("mute_toggle_cur", sd, frame_of(18'h0A5A5, 18'h3FFFF));
      sample_frame(4, -1, 18'h0, 1'b0, sd, lr);
      chk("mute_toggle_next", sd, 64'd0);

      run_setup(18'h3FFFF, 18'h00000, 1'b0);
      sample_frame(66, 5, 18'h20000, 1'b0, sd, lr);
      chk("stable_cur", sd, frame_of(18'h1FFFF, 18'h20000));
      sample_frame(4, -1, 18'h0, 1'b0, sd, lr);
      chk("stable_next", sd, frame_of(18'h00000, 18'h20000));

      wait_tick(400, n);
      chk("tick_seen_rst", 64'(tick48k), 64'd1);
      repeat (224) @(posedge clk);
      @(negedge clk);
      chk("slot40_lrclk", 64'(i2s_lrclk), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midframe_reset", 64'({tick48k, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
      rst = 1'b0;
      wait_tick(400, n);
      chk("tick_after_rst", 64'(n), 64'd192);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
